// File: rtl/cpu_vram_write_poster.sv
`timescale 1ns/1ps
// Posted-write buffer: catches Z80 writes into the VRAM window, queues them and
// replays each one as a setup/pulse/hold SRAM write cycle on the back VRAM port.
//   state   | meaning
//   S_IDLE  | bus released; pops the FIFO head when data waits and no copy runs
//   S_SETUP | address/data/oe driven, WE_n still high
//   S_PULSE | WE_n low for WR_PULSE cycles
//   S_HOLD  | WE_n high again, address/data held one more cycle
module cpu_vram_write_poster #(
    parameter logic [2:0] WIN_BASE   = 3'b100,
    parameter int         FIFO_DEPTH = 8,
    parameter int         WR_PULSE   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   cpu_addr,
    input  logic [7:0]                    cpu_data,
    input  logic                          cpu_wr,
    input  logic                          cpu_mreq,
    input  logic                          copy_in_progress,
    output logic [12:0]                   back_vram_addr,
    output logic [7:0]                    back_vram_data_out,
    output logic                          back_vram_data_oe,
    output logic                          back_vram_wr_low,
    output logic                          bus_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
    localparam logic [PW:0]   FULL_CNT   = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(WR_PULSE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;
    state_t state;

    logic        mreq_s1, mreq_s2, wr_s1, wr_s2, wr_act_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic        wr_act, strobe, push, pop, do_push, full;

    logic [20:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] pulse_cnt;

    // Sync flops idle high so release from reset never looks like a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreq_s1  <= 1'b1;
            mreq_s2  <= 1'b1;
            wr_s1    <= 1'b1;
            wr_s2    <= 1'b1;
            wr_act_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            mreq_s1  <= cpu_mreq;
            mreq_s2  <= mreq_s1;
            wr_s1    <= cpu_wr;
            wr_s2    <= wr_s1;
            wr_act_q <= wr_act;
            addr_q   <= cpu_addr;
            data_q   <= cpu_data;
        end
    end

    assign wr_act  = ~mreq_s2 & ~wr_s2;
    assign strobe  = wr_act & ~wr_act_q;
    assign push    = strobe && (addr_q[15:13] == WIN_BASE);
    assign full    = (fifo_count == FULL_CNT);
    assign pop     = (state == S_IDLE) && (fifo_count != '0) && !copy_in_progress;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {addr_q[12:0], data_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            pulse_cnt          <= '0;
            back_vram_addr     <= '0;
            back_vram_data_out <= '0;
            back_vram_data_oe  <= 1'b0;
            back_vram_wr_low   <= 1'b1;
            bus_busy           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {back_vram_addr, back_vram_data_out} <= mem[rd_ptr];
                        back_vram_data_oe <= 1'b1;
                        bus_busy          <= 1'b1;
                        state             <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    back_vram_wr_low <= 1'b0;
                    pulse_cnt        <= PULSE_LOAD;
                    state            <= S_PULSE;
                end
                S_PULSE: begin
                    if (pulse_cnt == '0) begin
                        back_vram_wr_low <= 1'b1;
                        state            <= S_HOLD;
                    end else begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    back_vram_data_oe <= 1'b0;
                    bus_busy          <= 1'b0;
                    state             <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_vram_write_poster.sv
`timescale 1ns/1ps
// Bench for cpu_vram_write_poster: Z80-style writes against a queue of expected
// SRAM writes, with a monitor that checks every write cycle's shape and content.
module tb_cpu_vram_write_poster;
    localparam int WR_PULSE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_wr, cpu_mreq, copy_in_progress;
    logic [12:0] back_vram_addr;
    logic [7:0]  back_vram_data_out;
    logic        back_vram_data_oe, back_vram_wr_low, bus_busy, overflow;
    logic [3:0]  fifo_count;

    cpu_vram_write_poster dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_wr(cpu_wr), .cpu_mreq(cpu_mreq), .copy_in_progress(copy_in_progress),
        .back_vram_addr(back_vram_addr), .back_vram_data_out(back_vram_data_out),
        .back_vram_data_oe(back_vram_data_oe), .back_vram_wr_low(back_vram_wr_low),
        .bus_busy(bus_busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int writes_seen = 0;
    logic [20:0] exp_q[$];
    int fall_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [15:0] a);
        return a[15:13] == 3'b100;
    endfunction

    always @(posedge clk) cyc++;

    // SRAM-side monitor: each WE_n pulse must carry the oldest expected write.
    logic        prev_wr = 1'b1;
    int          pulse_len = 0, oe_len = 0, busy_len = 0;
    logic [12:0] cap_a;
    logic [7:0]  cap_d;
    logic [20:0] mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wr = 1'b1; pulse_len = 0; oe_len = 0; busy_len = 0;
        end else begin
            if (!back_vram_wr_low && prev_wr) begin
                chk("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", back_vram_addr, mon_e[20:8]);
                    chk("wr_data", back_vram_data_out, mon_e[7:0]);
                end
                cap_a = back_vram_addr; cap_d = back_vram_data_out;
                pulse_len = 0;
                writes_seen++;
                fall_cyc.push_back(cyc);
            end
            if (!back_vram_wr_low) begin
                pulse_len++;
                chk("addr_stable", back_vram_addr, cap_a);
                chk("data_stable", back_vram_data_out, cap_d);
                chk("oe_in_pulse", back_vram_data_oe, 1);
            end
            if (back_vram_wr_low && !prev_wr) chk("pulse_len", pulse_len, WR_PULSE);
            if (back_vram_data_oe) oe_len++;
            else begin
                if (oe_len != 0) chk("oe_len", oe_len, WR_PULSE + 2);
                oe_len = 0;
            end
            if (bus_busy) busy_len++;
            else begin
                if (busy_len != 0) chk("busy_len", busy_len, WR_PULSE + 2);
                busy_len = 0;
            end
            prev_wr = back_vram_wr_low;
        end
    end

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input bit io,
                             input int low_ns, input int gap_ns);
        cpu_addr = a; cpu_data = d;
        #7;
        if (!io) cpu_mreq = 1'b0;
        cpu_wr = 1'b0;
        #(low_ns);
        cpu_wr = 1'b1; cpu_mreq = 1'b1;
        #(gap_ns);
    endtask

    task automatic wait_wr_low(input int budget);
        int n = 0;
        while (back_vram_wr_low !== 1'b0 && n < budget) begin @(posedge clk); #1; n++; end
        chk("wait_wr_low_timeout", n < budget, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((fifo_count !== 4'd0 || bus_busy !== 1'b0) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_idle_timeout", n < budget, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_low"}, back_vram_wr_low, 1);
        chk({tag, "_oe"}, back_vram_data_oe, 0);
        chk({tag, "_addr"}, back_vram_addr, 0);
        chk({tag, "_data"}, back_vram_data_out, 0);
        chk({tag, "_busy"}, bus_busy, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        int n, w0;
        logic [15:0] a;
        logic [7:0]  d;

        rst_n = 1'b0; cpu_addr = '0; cpu_data = '0; cpu_wr = 1'b1; cpu_mreq = 1'b1;
        copy_in_progress = 1'b0;
        #33;
        chk_reset_outputs("por");
        #20 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single write, with latency measured from the WR falling edge.
        w0 = writes_seen;
        cpu_addr = 16'h8123; cpu_data = 8'hA5;
        exp_q.push_back({13'h0123, 8'hA5});
        @(posedge clk); #7;
        cpu_mreq = 1'b0; cpu_wr = 1'b0;
        n = 0;
        while (fifo_count !== 4'd1 && n < 10) begin @(posedge clk); #1; n++; end
        chk("push_latency", n, 3);
        while (back_vram_wr_low !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
        chk("wr_low_latency", n, 5);
        chk("single_addr", back_vram_addr, 13'h0123);
        chk("single_data", back_vram_data_out, 8'hA5);
        cpu_wr = 1'b1; cpu_mreq = 1'b1;
        wait_idle(50);
        chk("single_writes", writes_seen - w0, 1);
        chk("single_count", fifo_count, 0);

        // Writes outside the window and an I/O write are ignored.
        w0 = writes_seen;
        cpu_write(16'h7FFF, 8'h11, 1'b0, 100, 200);
        cpu_write(16'hA000, 8'h22, 1'b0, 100, 200);
        cpu_write(16'h8000, 8'h33, 1'b1, 100, 200);
        repeat (20) @(posedge clk);
        #1;
        chk("oow_count", fifo_count, 0);
        chk("oow_writes", writes_seen - w0, 0);
        chk("oow_wr_low", back_vram_wr_low, 1);

        // WR held low for 20 clk produces one write only.
        w0 = writes_seen;
        d = 8'($urandom);
        exp_q.push_back({13'h1FFF, d});
        cpu_write(16'h9FFF, d, 1'b0, 400, 100);
        wait_idle(100);
        repeat (10) @(posedge clk);
        #1;
        chk("long_wr_writes", writes_seen - w0, 1);
        chk("long_wr_queue", exp_q.size(), 0);

        // Copier blocks draining: the first 8 of 10 writes survive.
        w0 = writes_seen;
        copy_in_progress = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 16'h8000 | 16'($urandom & 32'h1FFF);
            d = 8'($urandom);
            if (exp_q.size() < 8) exp_q.push_back({a[12:0], d});
            cpu_write(a, d, 1'b0, 100, 300);
        end
        @(posedge clk); #1;
        chk("ovf_count", fifo_count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_blocked", writes_seen - w0, 0);
        fall_cyc.delete();
        copy_in_progress = 1'b0;
        wait_idle(200);
        chk("drain_writes", fall_cyc.size(), 8);
        for (int i = 1; i < fall_cyc.size(); i++)
            chk("drain_spacing", fall_cyc[i] - fall_cyc[i-1], WR_PULSE + 3);
        chk("drain_queue", exp_q.size(), 0);
        chk("ovf_sticky", overflow, 1);

        // Copier request arriving mid-pulse lets the current write finish.
        w0 = writes_seen;
        a = 16'h8000 | 16'($urandom & 32'h1FFF); d = 8'($urandom);
        exp_q.push_back({a[12:0], d});
        cpu_write(a, d, 1'b0, 60, 0);
        wait_wr_low(30);
        copy_in_progress = 1'b1;
        a = 16'h8000 | 16'($urandom & 32'h1FFF); d = 8'($urandom);
        exp_q.push_back({a[12:0], d});
        cpu_write(a, d, 1'b0, 100, 100);
        repeat (30) @(posedge clk);
        #1;
        chk("copy_mid_writes", writes_seen - w0, 1);
        chk("copy_mid_count", fifo_count, 1);
        chk("copy_mid_busy", bus_busy, 0);
        copy_in_progress = 1'b0;
        wait_idle(50);
        chk("copy_mid_after", writes_seen - w0, 2);
        chk("copy_mid_queue", exp_q.size(), 0);

        // Reset in the middle of a pulse with 3 entries still queued.
        copy_in_progress = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'h8000 | 16'($urandom & 32'h1FFF); d = 8'($urandom);
            exp_q.push_back({a[12:0], d});
            cpu_write(a, d, 1'b0, 100, 100);
        end
        @(posedge clk); #1;
        chk("rst_pre_count", fifo_count, 4);
        copy_in_progress = 1'b0;
        wait_wr_low(30);
        @(posedge clk); #4;
        chk("rst_pre_count3", fifo_count, 3);
        chk("rst_pre_wr_low", back_vram_wr_low, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        exp_q.delete();
        w0 = writes_seen;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("post_rst_writes", writes_seen - w0, 0);
        chk("post_rst_count", fifo_count, 0);
        chk("post_rst_wr_low", back_vram_wr_low, 1);

        // Random CPU writes 400 ns apart never overflow.
        w0 = writes_seen;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom);
            if (i % 3 == 0) a[15:13] = 3'b100;
            d = 8'($urandom);
            if (in_win(a)) exp_q.push_back({a[12:0], d});
            cpu_write(a, d, 1'b0, 100, 293);
        end
        wait_idle(100);
        chk("b2b_overflow", overflow, 0);
        chk("b2b_queue", exp_q.size(), 0);
        chk("b2b_count", fifo_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
